// File: rtl/sky130_ajc_ip_por.sv
// Behavioural power-on-reset controller for the sky130 analog supply domain:
// hysteretic supply comparator, glitch filter, one-shot hold-off and debug overrides.
module sky130_ajc_ip_por #(
  parameter int  FILT_CYCLES    = 16,
  parameter int  STARTUP_CYCLES = 64,
  parameter int  LONG_CYCLES    = 65536,
  parameter int  SHORT_CYCLES   = 256,
  parameter real VTRIP_BASE     = 2.6,
  parameter real VTRIP_STEP     = 0.1,
  parameter real VHYST          = 0.05
) (
  input  logic       clk,
  input  logic       rst_n,
  input  real        avdd,
  input  logic       avss,
  input  logic       dvdd,
  input  logic       dvss,
  input  real        vbg_1v2,
  input  logic [2:0] otrip,
  input  logic       force_pdn,
  input  logic       force_ena_rc_osc,
  input  logic       force_dis_rc_osc,
  input  logic       force_short_oneshot,
  input  logic       isrc_sel,
  input  real        ibg_200n,
  output logic       porb_h,
  output logic       porb,
  output logic       por,
  output logic       osc_ck,
  output real        itest,
  output logic       pwup_filt,
  output logic       vin,
  output logic       startup_timed_out,
  output logic       por_timed_out
);

  localparam int CW = $clog2(LONG_CYCLES + 1);

  typedef enum logic [2:0] {
    ST_STARTUP,
    ST_WAIT,
    ST_FILTER,
    ST_ONESHOT,
    ST_RELEASED
  } state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic            pwup_reg, pwup_next;
  logic            startup_done_reg, startup_done_next;
  logic            por_done_reg, por_done_next;
  logic            vin_hold_reg;
  logic            brownout;
  logic            osc_en;
  logic [CW-1:0]   oneshot_last;
  real             vtrip;

  logic unused_supplies;
  assign unused_supplies = avss ^ dvdd ^ dvss;

  assign vtrip = (VTRIP_BASE + VTRIP_STEP * real'(otrip)) * (vbg_1v2 / 1.2);

  // Inside the hysteresis band the comparator keeps its last clocked decision.
  always_comb begin
    vin = vin_hold_reg;
    if (force_pdn)
      vin = 1'b0;
    else if (avdd >= vtrip)
      vin = 1'b1;
    else if (avdd < vtrip - VHYST)
      vin = 1'b0;
  end

  assign itest = force_pdn ? 0.0 : (isrc_sel ? ibg_200n : 200e-9);

  assign brownout = ((state_reg == ST_ONESHOT) || (state_reg == ST_RELEASED)) && !vin;
  assign osc_en   = force_ena_rc_osc |
                    (~force_dis_rc_osc & ((state_reg != ST_RELEASED) | brownout));
  assign osc_ck   = clk & osc_en;

  assign oneshot_last = force_short_oneshot ? CW'(SHORT_CYCLES - 1) : CW'(LONG_CYCLES - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= ST_STARTUP;
      cnt_reg          <= '0;
      pwup_reg         <= 1'b0;
      startup_done_reg <= 1'b0;
      por_done_reg     <= 1'b0;
      vin_hold_reg     <= 1'b0;
    end else begin
      state_reg        <= state_next;
      cnt_reg          <= cnt_next;
      pwup_reg         <= pwup_next;
      startup_done_reg <= startup_done_next;
      por_done_reg     <= por_done_next;
      vin_hold_reg     <= vin;
    end
  end

  // Brown-out bypasses the oscillator gate and outranks any count completion.
  always_comb begin
    state_next        = state_reg;
    cnt_next          = cnt_reg;
    pwup_next         = pwup_reg;
    startup_done_next = startup_done_reg;
    por_done_next     = por_done_reg;
    if (brownout) begin
      state_next    = ST_WAIT;
      cnt_next      = '0;
      pwup_next     = 1'b0;
      por_done_next = 1'b0;
    end else if (osc_en) begin
      case (state_reg)
        ST_STARTUP: begin
          if (cnt_reg == CW'(STARTUP_CYCLES - 1)) begin
            state_next        = ST_WAIT;
            startup_done_next = 1'b1;
            cnt_next          = '0;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        ST_WAIT: begin
          if (vin) begin
            state_next = ST_FILTER;
            cnt_next   = '0;
          end
        end
        ST_FILTER: begin
          // The WAIT->FILTER edge already saw the first high sample.
          if (!vin) begin
            state_next = ST_WAIT;
            cnt_next   = '0;
          end else if (cnt_reg == CW'(FILT_CYCLES - 2)) begin
            state_next = ST_ONESHOT;
            pwup_next  = 1'b1;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        ST_ONESHOT: begin
          if (cnt_reg >= oneshot_last) begin
            state_next    = ST_RELEASED;
            por_done_next = 1'b1;
            cnt_next      = '0;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        ST_RELEASED: begin
          cnt_next = '0;
        end
        default: begin
          state_next = ST_STARTUP;
          cnt_next   = '0;
        end
      endcase
    end
  end

  assign porb              = (state_reg == ST_RELEASED);
  assign porb_h            = porb;
  assign por               = ~porb;
  assign pwup_filt         = pwup_reg;
  assign startup_timed_out = startup_done_reg;
  assign por_timed_out     = por_done_reg;

endmodule

// File: tb/tb_sky130_ajc_ip_por.sv
// Scoreboard bench for sky130_ajc_ip_por: expected values are queued when stimulus
// is applied and popped when the matching DUT response is sampled.
module tb_sky130_ajc_ip_por;

  logic       clk = 1'b0;
  logic       rst_n;
  real        avdd, vbg_1v2, ibg_200n;
  logic       avss, dvdd, dvss;
  logic [2:0] otrip;
  logic       force_pdn, force_ena_rc_osc, force_dis_rc_osc, force_short_oneshot, isrc_sel;
  logic       porb_h, porb, por, osc_ck, pwup_filt, vin, startup_timed_out, por_timed_out;
  real        itest;

  sky130_ajc_ip_por dut (
    .clk(clk), .rst_n(rst_n), .avdd(avdd), .avss(avss), .dvdd(dvdd), .dvss(dvss),
    .vbg_1v2(vbg_1v2), .otrip(otrip), .force_pdn(force_pdn),
    .force_ena_rc_osc(force_ena_rc_osc), .force_dis_rc_osc(force_dis_rc_osc),
    .force_short_oneshot(force_short_oneshot), .isrc_sel(isrc_sel), .ibg_200n(ibg_200n),
    .porb_h(porb_h), .porb(porb), .por(por), .osc_ck(osc_ck), .itest(itest),
    .pwup_filt(pwup_filt), .vin(vin), .startup_timed_out(startup_timed_out),
    .por_timed_out(por_timed_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string tag;
    int    val;
  } exp_t;
  exp_t exp_q[$];

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic push_exp(input string tag, input int val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic pop_check(input int got);
    exp_t e;
    if (exp_q.size() == 0) begin
      check("scoreboard_underflow", got, -1);
    end else begin
      e = exp_q.pop_front();
      check(e.tag, got, e.val);
      $display("txn %s got=%0d exp=%0d", e.tag, got, e.val);
    end
  endtask

  function automatic int sig_val(input int sel);
    case (sel)
      0: return int'(startup_timed_out);
      1: return int'(pwup_filt);
      2: return int'(porb);
      default: return int'(por_timed_out);
    endcase
  endfunction

  function automatic int itest_na();
    return $rtoi(itest * 1.0e9 + 0.5);
  endfunction

  // Cycles from base until the selected signal reads 1; -1 when the budget runs out.
  task automatic wait_rise(input int sel, input int base, input int budget, output int n);
    n = -1;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (sig_val(sel) == 1) begin
        n = cyc - base;
        break;
      end
    end
  endtask

  task automatic release_after(input string tag, input int exp_cycles, input int budget);
    int base;
    int n;
    base = cyc;
    push_exp(tag, exp_cycles);
    wait_rise(2, base, budget, n);
    pop_check(n);
  endtask

  initial begin
    int base;
    int n;
    int seen;

    rst_n = 1'b0; avdd = 3.1; vbg_1v2 = 1.2; ibg_200n = 0.0;
    avss = 1'b0; dvdd = 1'b1; dvss = 1'b0; otrip = 3'd0;
    force_pdn = 1'b0; force_ena_rc_osc = 1'b0; force_dis_rc_osc = 1'b0;
    force_short_oneshot = 1'b1; isrc_sel = 1'b0;

    push_exp("rst_por", 1); push_exp("rst_porb", 0); push_exp("rst_porb_h", 0);
    push_exp("rst_pwup", 0); push_exp("rst_sto", 0); push_exp("rst_pto", 0);
    repeat (3) @(negedge clk);
    pop_check(por); pop_check(porb); pop_check(porb_h);
    pop_check(pwup_filt); pop_check(startup_timed_out); pop_check(por_timed_out);

    // Power-up sequence with the short one-shot
    rst_n = 1'b1;
    base = cyc;
    push_exp("startup_cyc", 64); push_exp("pwup_cyc", 80); push_exp("release_cyc", 336);
    wait_rise(0, base, 200, n);  pop_check(n);
    wait_rise(1, base, 200, n);  pop_check(n);
    wait_rise(2, base, 1000, n); pop_check(n);
    push_exp("rel_pto", 1); push_exp("rel_porb_h", 1); push_exp("rel_por", 0);
    pop_check(por_timed_out); pop_check(porb_h); pop_check(por);
    push_exp("rel_osc_stopped", 0);
    @(posedge clk); #1;
    pop_check(osc_ck);

    // Brown-out, long low period, then recovery
    @(negedge clk); avdd = 2.0;
    push_exp("bo_vin", 0);
    #1 pop_check(vin);
    push_exp("bo_porb", 0); push_exp("bo_por", 1); push_exp("bo_pwup", 0);
    push_exp("bo_pto", 0); push_exp("bo_osc_ck", 1);
    @(posedge clk); #1;
    pop_check(porb); pop_check(por); pop_check(pwup_filt);
    pop_check(por_timed_out); pop_check(osc_ck);
    repeat (10000) @(posedge clk);
    push_exp("low_vin", 0); push_exp("low_porb", 0);
    @(negedge clk);
    pop_check(vin); pop_check(porb);
    avdd = 3.1;
    release_after("rise_release", 272, 1000);

    // Short glitch on the supply must not reach pwup_filt or porb
    @(negedge clk); avdd = 2.0;
    repeat (3) @(negedge clk);
    avdd = 3.1;
    seen = 0;
    for (int i = 0; i < 310; i++) begin
      @(negedge clk);
      if (i == 9) avdd = 2.0;
      seen = seen | int'(pwup_filt) | int'(porb);
    end
    push_exp("glitch_seen", 0);
    pop_check(seen);
    @(negedge clk); avdd = 3.1;
    release_after("glitch_recover", 272, 1000);

    // Trip level selection and hysteresis
    @(negedge clk); otrip = 3'd7;
    push_exp("trip7_vin", 0);
    #1 pop_check(vin);
    @(negedge clk); otrip = 3'd5;
    push_exp("trip5_vin", 1);
    #1 pop_check(vin);
    repeat (2) @(negedge clk);
    avdd = 3.06;
    push_exp("hyst_306_vin", 1); push_exp("hyst_306_hold", 1);
    #1 pop_check(vin);
    repeat (3) @(negedge clk);
    pop_check(vin);
    avdd = 3.04;
    push_exp("hyst_304_vin", 0);
    #1 pop_check(vin);
    repeat (2) @(negedge clk);
    avdd = 3.1; otrip = 3'd0;
    release_after("trip_recover", 272, 1000);

    // Forced power-down
    @(negedge clk); force_pdn = 1'b1;
    push_exp("pdn_vin", 0); push_exp("pdn_itest_na", 0);
    #1 pop_check(vin); pop_check(itest_na());
    push_exp("pdn_porb", 0);
    @(posedge clk); #1 pop_check(porb);
    @(negedge clk); force_pdn = 1'b0;
    release_after("pdn_recover", 272, 1000);

    // Test current source selection
    @(negedge clk); isrc_sel = 1'b1; ibg_200n = 150e-9;
    push_exp("itest_ext_na", 150);
    #1 pop_check(itest_na());
    isrc_sel = 1'b0;
    push_exp("itest_int_na", 200);
    #1 pop_check(itest_na());

    // Forced oscillator enable while released
    @(negedge clk); force_ena_rc_osc = 1'b1;
    push_exp("ena_osc_hi", 1); push_exp("ena_osc_lo", 0);
    @(posedge clk); #1 pop_check(osc_ck);
    @(negedge clk); #1 pop_check(osc_ck);
    force_ena_rc_osc = 1'b0;
    push_exp("ena_off_osc", 0);
    @(posedge clk); #1 pop_check(osc_ck);

    // Forced oscillator disable freezes the one-shot
    @(negedge clk); avdd = 2.0;
    @(negedge clk); avdd = 3.1;
    base = cyc;
    push_exp("dis_pwup_cyc", 16);
    wait_rise(1, base, 100, n); pop_check(n);
    force_dis_rc_osc = 1'b1;
    push_exp("dis_osc_ck", 0);
    @(posedge clk); #1 pop_check(osc_ck);
    repeat (600) @(posedge clk);
    push_exp("dis_porb_frozen", 0); push_exp("dis_pwup_held", 1);
    #1 pop_check(porb); pop_check(pwup_filt);
    @(negedge clk); force_dis_rc_osc = 1'b0;
    release_after("dis_resume_release", 256, 1000);

    // Long one-shot
    @(negedge clk); force_short_oneshot = 1'b0; avdd = 2.0;
    @(negedge clk); avdd = 3.1;
    release_after("long_release", 65552, 70000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
